fc_argmax_classifier: RTL and testbench
=======================================

Name: fc_argmax_classifier

Overview:
- Downstream stage of the fully-connected neuron. Consumes one signed FC score per clock, one score per class weight set, in class order 0..NUM_CLASSES-1.
- Tracks the running maximum across a frame and emits the winning class index and its score.
- Holds the verdict on an output valid/ready handshake and stalls the input until the verdict is taken.

Parameters:
- NUM_CLASSES, 4, FC scores per frame (one per weight set); must be >= 2.
- SCORE_W, 8, width of each signed two's-complement FC score.
- CLS_W, $clog2(NUM_CLASSES), width of the class index.
- REJECT_THRESH, 0, signed reject threshold; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous frame abort; discards any partial frame.
- score_valid  in  1  score_data carries a valid FC result.
- score_ready  out  1  block accepts a score this cycle.
- score_data  in  SCORE_W  signed FC neuron result.
- cls_valid  out  1  verdict available.
- cls_ready  in  1  consumer takes the verdict.
- cls_id  out  CLS_W  index of the winning class.
- cls_score  out  SCORE_W  score of the winning class.
- cls_reject  out  1  winning score is below threshold (optional feature only).

Behaviour:
- Reset is asynchronous on rst_n low. While in reset:
  - state = ACCUM, cnt = 0, best_id = 0, best_score = most-negative value (e.g. 8'h80).
  - cls_valid = 0, cls_id = 0, cls_score = 0, cls_reject = 0, score_ready = 0.
- score_ready = 1 in ACCUM and 0 in HOLD. A score is accepted only when score_valid && score_ready.
- FSM, two states:
  - ACCUM:
    - Each accepted score: if cnt == 0 or score_data > best_score (signed compare), load best_score = score_data and best_id = cnt. Then increment cnt.
    - On the accept with cnt == NUM_CLASSES-1: register the verdict from the updated best (the last score is included), set cls_valid = 1, clear cnt to 0, and go to HOLD.
    - Latency: cls_valid rises the clock edge after the last score is accepted.
  - HOLD:
    - cls_id, cls_score and cls_reject stay stable while cls_valid && !cls_ready.
    - On cls_valid && cls_ready: drop cls_valid next cycle, return to ACCUM, reset best_score to most-negative.
    - score_ready is 0 throughout HOLD, so no score is lost. The first score of the next frame is accepted the cycle after the handshake.
- Ties go to the lowest index (strict greater-than compare).
- The cnt == 0 forced load makes a frame of all most-negative scores report class 0.
- Input gaps: score_valid may drop mid-frame. cnt and best are held and no timeout applies.
- flush:
  - In ACCUM: cnt = 0 and best is reset. A score presented in the same cycle is dropped (flush wins).
  - In HOLD: ignored. A completed verdict is never discarded.
- rst_n asserted mid-frame or in HOLD: everything returns to the reset values immediately, and the verdict is lost.
- cnt wraps only through the terminal compare and never exceeds NUM_CLASSES-1.

Optional Feature:
- Macro: FC_ARGMAX_REJECT_EN.
- Defined: at verdict registration, cls_reject = (best_score < REJECT_THRESH), signed compare. It is held with the other outputs in HOLD and cleared on the handshake.
- Undefined: cls_reject is tied to 0, REJECT_THRESH is unused, and no comparator is synthesised.

Test Plan:
- Reset, then scores 8'h08, 8'hF8, 8'h04, 8'h04 on consecutive cycles with cls_ready = 1 → one cycle after the 4th accept: cls_valid = 1, cls_id = 0, cls_score = 8'h08. cls_valid drops the next cycle.
- Scores 8'hF8, 8'h08, 8'h04, 8'h04 → cls_id = 1, cls_score = 8'h08. Scores 8'h04, 8'hF8, 8'h08, 8'h00 → cls_id = 2.
- Tie and negatives: 8'hFE, 8'hFC, 8'hFE, 8'hFF → cls_id = 3, score 8'hFF. Then 8'h05, 8'h05, 8'h02, 8'h05 → cls_id = 0.
- Backpressure: hold cls_ready = 0 for 5 cycles after a verdict, with score_valid = 1 → score_ready stays 0, outputs stay stable, and the next frame starts only after cls_ready = 1.
- Flush and reset: 2 scores, then flush, then 4 scores 1, 2, 3, 9 → cls_id = 3, score 8'h09 (pre-flush scores ignored). Assert rst_n = 0 mid-frame → every output is 0 without waiting for a clock edge.
- FC_ARGMAX_REJECT_EN with REJECT_THRESH = 2: frame 8'hF8, 8'h01, 8'hF8, 8'hF8 → cls_id = 1, cls_reject = 1. Frame 8'h04, 0, 0, 0 → cls_reject = 0. With the macro undefined, cls_reject stays 0.

Source files
------------

// File: rtl/fc_argmax_classifier_if.sv
// Score-in / verdict-out handshake bundle for fc_argmax_classifier.
// master: the side that drives FC scores and consumes verdicts.
// slave:  the classifier itself.
interface fc_argmax_classifier_if #(
   parameter int SCORE_W = 8,
   parameter int CLS_W   = 2
);
   logic               score_valid;
   logic               score_ready;
   logic [SCORE_W-1:0] score_data;
   logic               cls_valid;
   logic               cls_ready;
   logic [CLS_W-1:0]   cls_id;
   logic [SCORE_W-1:0] cls_score;
   logic               cls_reject;

   modport master (
      output score_valid, score_data, cls_ready,
      input  score_ready, cls_valid, cls_id, cls_score, cls_reject
   );

   modport slave (
      input  score_valid, score_data, cls_ready,
      output score_ready, cls_valid, cls_id, cls_score, cls_reject
   );
endinterface

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: consumes NUM_CLASSES signed FC scores per frame,
// tracks the running maximum and presents the winning class index/score
// on a valid/ready handshake. Input is stalled while a verdict is held.
// Optional macro FC_ARGMAX_REJECT_EN: flags verdicts whose winning score
// is below REJECT_THRESH on cls_reject (tied low when undefined).
module fc_argmax_classifier #(
   parameter int NUM_CLASSES   = 4,
   parameter int SCORE_W       = 8,
   parameter int CLS_W         = $clog2(NUM_CLASSES),
   parameter int REJECT_THRESH = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   fc_argmax_classifier_if.slave bus
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};
   localparam logic [CLS_W-1:0]          LAST_CNT = CLS_W'(NUM_CLASSES - 1);

   state_t                     state_reg, state_next;
   logic                       run_reg;
   logic [CLS_W-1:0]           cnt_reg, cnt_next;
   logic [CLS_W-1:0]           best_id_reg, best_id_next;
   logic signed [SCORE_W-1:0]  best_score_reg, best_score_next;
   logic                       cls_valid_reg, cls_valid_next;
   logic [CLS_W-1:0]           cls_id_reg, cls_id_next;
   logic [SCORE_W-1:0]         cls_score_reg, cls_score_next;
   logic                       cls_reject_reg, cls_reject_next;

   logic                       score_ready;
   logic                       accept;
   logic                       take;
   logic signed [SCORE_W-1:0]  cand_score;
   logic [CLS_W-1:0]           cand_id;
   logic                       rej_cand;

   assign accept = bus.score_valid && score_ready;

   // Candidate best after folding in the current score; first score of a
   // frame always loads so an all-most-negative frame still reports class 0.
   always_comb begin
      take       = (cnt_reg == '0) || ($signed(bus.score_data) > best_score_reg);
      cand_score = take ? $signed(bus.score_data) : best_score_reg;
      cand_id    = take ? cnt_reg : best_id_reg;
   end

`ifdef FC_ARGMAX_REJECT_EN
   localparam logic signed [SCORE_W-1:0] THRESH_S = SCORE_W'(REJECT_THRESH);
   assign rej_cand = (cand_score < THRESH_S);
`else
   logic unused_thresh;
   assign unused_thresh = ^REJECT_THRESH;
   assign rej_cand      = 1'b0;
`endif

   // State register, plus a flag that keeps score_ready low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ACCUM;
         run_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
      end
   end

   // Next-state logic: leave ACCUM on the terminal accept, leave HOLD on handshake.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACCUM: if (!flush && accept && (cnt_reg == LAST_CNT)) state_next = HOLD;
         HOLD:  if (cls_valid_reg && bus.cls_ready)            state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // FSM outputs: scores are accepted only while accumulating.
   always_comb begin
      score_ready = (state_reg == ACCUM) && run_reg;
   end

   // Datapath next values: running max, frame counter and verdict registers.
   always_comb begin
      cnt_next        = cnt_reg;
      best_id_next    = best_id_reg;
      best_score_next = best_score_reg;
      cls_valid_next  = cls_valid_reg;
      cls_id_next     = cls_id_reg;
      cls_score_next  = cls_score_reg;
      cls_reject_next = cls_reject_reg;
      case (state_reg)
         ACCUM: begin
            if (flush) begin
               // Flush wins over a same-cycle score.
               cnt_next        = '0;
               best_id_next    = '0;
               best_score_next = MOST_NEG;
            end else if (accept) begin
               best_id_next    = cand_id;
               best_score_next = cand_score;
               if (cnt_reg == LAST_CNT) begin
                  cnt_next        = '0;
                  cls_valid_next  = 1'b1;
                  cls_id_next     = cand_id;
                  cls_score_next  = cand_score;
                  cls_reject_next = rej_cand;
               end else begin
                  cnt_next = cnt_reg + CLS_W'(1);
               end
            end
         end
         HOLD: begin
            // flush is deliberately ignored here: a finished verdict is kept.
            if (cls_valid_reg && bus.cls_ready) begin
               cls_valid_next  = 1'b0;
               cls_reject_next = 1'b0;
               best_id_next    = '0;
               best_score_next = MOST_NEG;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; async reset drops any partial frame or held verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         best_id_reg    <= '0;
         best_score_reg <= MOST_NEG;
         cls_valid_reg  <= 1'b0;
         cls_id_reg     <= '0;
         cls_score_reg  <= '0;
         cls_reject_reg <= 1'b0;
      end else begin
         cnt_reg        <= cnt_next;
         best_id_reg    <= best_id_next;
         best_score_reg <= best_score_next;
         cls_valid_reg  <= cls_valid_next;
         cls_id_reg     <= cls_id_next;
         cls_score_reg  <= cls_score_next;
         cls_reject_reg <= cls_reject_next;
      end
   end

   assign bus.score_ready = score_ready;
   assign bus.cls_valid   = cls_valid_reg;
   assign bus.cls_id      = cls_id_reg;
   assign bus.cls_score   = cls_score_reg;
   assign bus.cls_reject  = cls_reject_reg;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed testbench for fc_argmax_classifier (NUM_CLASSES=4, SCORE_W=8,
// REJECT_THRESH=2). Reject expectations apply only when
// FC_ARGMAX_REJECT_EN is defined; otherwise cls_reject must stay 0.
module tb_fc_argmax_classifier;

   localparam int NUM_CLASSES = 4;
   localparam int SCORE_W     = 8;
   localparam int CLS_W       = 2;
`ifdef FC_ARGMAX_REJECT_EN
   localparam bit REJ_ON = 1'b1;
`else
   localparam bit REJ_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic flush;

   int checks_total  = 0;
   int checks_passed = 0;

   fc_argmax_classifier_if #(.SCORE_W(SCORE_W), .CLS_W(CLS_W)) bus ();

   fc_argmax_classifier #(
      .NUM_CLASSES   (NUM_CLASSES),
      .SCORE_W       (SCORE_W),
      .CLS_W         (CLS_W),
      .REJECT_THRESH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         checks_passed++;
   endtask

   // Present one score and return at the negedge after it was accepted.
   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      bus.score_valid = 1'b1;
      bus.score_data  = d;
      while (!bus.score_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.score_ready) check("ready_timeout", 32'(bus.score_ready), 1);
      @(negedge clk);
      bus.score_valid = 1'b0;
   endtask

   // Send a four-score frame (optional idle gap after the 2nd score) and
   // check the verdict; if cls_ready is high also check valid drops.
   task automatic run_frame(input string tag,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input int gap,
                            input int exp_id, input logic [7:0] exp_sc,
                            input logic exp_rj);
      send(s0);
      send(s1);
      repeat (gap) @(negedge clk);
      send(s2);
      send(s3);
      check({tag, "_valid"},  32'(bus.cls_valid),  1);
      check({tag, "_id"},     32'(bus.cls_id),     exp_id);
      check({tag, "_score"},  32'(bus.cls_score),  32'(exp_sc));
      check({tag, "_reject"}, 32'(bus.cls_reject), 32'(exp_rj & REJ_ON));
      $display("frame %s: id=%0d score=%02h reject=%0b", tag, bus.cls_id, bus.cls_score, bus.cls_reject);
      if (bus.cls_ready) begin
         @(negedge clk);
         check({tag, "_drop"}, 32'(bus.cls_valid), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      flush           = 1'b0;
      bus.score_valid = 1'b0;
      bus.score_data  = '0;
      bus.cls_ready   = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_valid",  32'(bus.cls_valid),   0);
      check("rst_id",     32'(bus.cls_id),      0);
      check("rst_score",  32'(bus.cls_score),   0);
      check("rst_reject", 32'(bus.cls_reject),  0);
      check("rst_ready",  32'(bus.score_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.score_ready), 1);

      // Basic argmax patterns, ties and negatives
      run_frame("f_a",   8'h08, 8'hF8, 8'h04, 8'h04, 0, 0, 8'h08, 1'b0);
      run_frame("f_b",   8'hF8, 8'h08, 8'h04, 8'h04, 0, 1, 8'h08, 1'b0);
      run_frame("f_c",   8'h04, 8'hF8, 8'h08, 8'h00, 0, 2, 8'h08, 1'b0);
      run_frame("f_neg", 8'hFE, 8'hFC, 8'hFE, 8'hFF, 0, 3, 8'hFF, 1'b1);
      run_frame("f_tie", 8'h05, 8'h05, 8'h02, 8'h05, 0, 0, 8'h05, 1'b0);
      run_frame("f_min", 8'h80, 8'h80, 8'h80, 8'h80, 0, 0, 8'h80, 1'b1);

      // Backpressure: verdict held, input stalled for 5 cycles
      bus.cls_ready = 1'b0;
      run_frame("f_bp", 8'h01, 8'h02, 8'h03, 8'h00, 0, 2, 8'h03, 1'b0);
      bus.score_valid = 1'b1;
      bus.score_data  = 8'h7F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_ready", 32'(bus.score_ready), 0);
         check("bp_valid", 32'(bus.cls_valid),   1);
         check("bp_id",    32'(bus.cls_id),      2);
         check("bp_score", 32'(bus.cls_score),   32'h03);
      end
      bus.score_valid = 1'b0;
      bus.cls_ready   = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(bus.cls_valid),   0);
      check("bp_release_ready", 32'(bus.score_ready), 1);
      run_frame("f_after_bp", 8'h7F, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7F, 1'b0);

      // Flush mid-frame drops partial frame and the same-cycle score
      send(8'h50);
      send(8'h60);
      flush           = 1'b1;
      bus.score_valid = 1'b1;
      bus.score_data  = 8'h7F;
      @(negedge clk);
      flush           = 1'b0;
      bus.score_valid = 1'b0;
      run_frame("f_flush", 8'h01, 8'h02, 8'h03, 8'h09, 3, 3, 8'h09, 1'b0);

      // Reject threshold frames
      run_frame("f_rej1", 8'hF8, 8'h01, 8'hF8, 8'hF8, 0, 1, 8'h01, 1'b1);
      run_frame("f_rej0", 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04, 1'b0);

      // Asynchronous reset while a verdict is held
      bus.cls_ready = 1'b0;
      run_frame("f_pre_rst", 8'h01, 8'h02, 8'h03, 8'h04, 0, 3, 8'h04, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid",  32'(bus.cls_valid),   0);
      check("arst_id",     32'(bus.cls_id),      0);
      check("arst_score",  32'(bus.cls_score),   0);
      check("arst_reject", 32'(bus.cls_reject),  0);
      check("arst_ready",  32'(bus.score_ready), 0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.cls_ready = 1'b1;
      run_frame("f_post_rst", 8'h10, 8'h20, 8'h30, 8'h40, 0, 3, 8'h40, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
